// File: rtl/opensync_parse_pkg.sv
// Shared definitions for the OpenSync TSMP node-side parser: FSM states,
// frame byte offsets and TSMP header constants.
package opensync_parse_pkg;

  localparam int unsigned IDX_W = 6;

  typedef enum logic [2:0] {
    IDLE_S    = 3'd0,
    HEAD_S    = 3'd1,
    PAYLOAD_S = 3'd2,
    TAIL_S    = 3'd3,
    DISCARD_S = 3'd4
  } state_e;

  localparam logic [IDX_W-1:0] DMAC_LAST_IDX = 6'd5;
  localparam logic [IDX_W-1:0] SMAC_OFS      = 6'd6;
  localparam logic [IDX_W-1:0] ETHTYPE_OFS   = 6'd12;
  localparam logic [IDX_W-1:0] TYPE_OFS      = 6'd14;
  localparam logic [IDX_W-1:0] SUBTYPE_OFS   = 6'd15;
  localparam logic [IDX_W-1:0] PAYLOAD_OFS   = 6'd16;
  localparam logic [IDX_W-1:0] TS_OFS        = 6'd17;
  localparam logic [IDX_W-1:0] SEQ_OFS       = 6'd25;
  localparam logic [IDX_W-1:0] MIN_LAST_IDX  = 6'd28;
  localparam logic [IDX_W-1:0] IDX_MAX       = 6'd63;

  localparam logic [15:0] TSMP_ETHTYPE       = 16'hFF01;
  localparam logic [7:0]  TSMP_TYPE_OPENSYNC = 8'h06;
  localparam logic [7:0]  OSYNC_SUB_TO_NODE  = 8'h03;

  // Byte index that sticks at IDX_MAX so long frames never wrap into the header.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_MAX) ? idx : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/opensync_field_shift.sv
// Byte-indexed shift-capture register: shifts in bytes FIRST_IDX..FIRST_IDX+WIDTH/8-1
// MSB first and exposes the next-cycle value so a commit can include the current byte.
module opensync_field_shift
  import opensync_parse_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [IDX_W-1:0] FIRST_IDX = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] val_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = FIRST_IDX + IDX_W'(WIDTH / 8 - 1);

  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] shifted;
  logic             hit;

  if (WIDTH > 8) begin : g_wide
    assign shifted = {val_q[WIDTH-9:0], byte_in};
  end else begin : g_byte
    assign shifted = byte_in;
  end

  // NOTE: every signal written here gets a value on every path; a path that
  // leaves one unassigned turns it into a latch.
  always_comb begin
    hit   = en && (idx >= FIRST_IDX) && (idx <= LAST_IDX);
    val_d = val_q;
    if (hit) val_d = shifted;
  end

  // NOTE: reset is synchronous (sampled on the clock edge), and state flops use
  // non-blocking assignments so all registers update together after the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign val_o = val_d;

endmodule

// File: rtl/opensync_parse.sv
// OpenSync TSMP node-side frame terminator: validates header and extracts the sync payload.
// Optional destination-MAC filter is compiled in with `define OPENSYNC_DMAC_CHECK_EN.
module opensync_parse
  import opensync_parse_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [47:0] iv_hcp_mac,
  input  logic [8:0]  iv_data,
  input  logic        i_data_wr,
  output logic        o_msg_valid,
  output logic [7:0]  ov_msg_type,
  output logic [63:0] ov_timestamp,
  output logic [31:0] ov_seq_id,
  output logic [47:0] ov_smac,
  output logic [15:0] ov_err_cnt
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             msg_valid_q, msg_valid_d;
  logic [7:0]       msg_type_q, msg_type_d;
  logic [63:0]      timestamp_q, timestamp_d;
  logic [31:0]      seq_id_q, seq_id_d;
  logic [47:0]      smac_q, smac_d;

  logic [7:0]       rx_byte;
  logic             rx_delim;
  logic             cap_en;
  logic             commit;
  logic             frame_bad;
  logic             hdr_ok;
  logic             dmac_bad;

  logic [7:0]       msg_type_sh;
  logic [63:0]      timestamp_sh;
  logic [31:0]      seq_id_sh;
  logic [47:0]      smac_sh;

  assign rx_byte  = iv_data[7:0];
  assign rx_delim = iv_data[8];

  opensync_field_shift #(.WIDTH(8), .FIRST_IDX(PAYLOAD_OFS)) u_msg_type (
    .clk(i_clk), .rst_n(i_rst_n), .en(cap_en), .idx(idx_q), .byte_in(rx_byte),
    .val_o(msg_type_sh)
  );

  opensync_field_shift #(.WIDTH(64), .FIRST_IDX(TS_OFS)) u_timestamp (
    .clk(i_clk), .rst_n(i_rst_n), .en(cap_en), .idx(idx_q), .byte_in(rx_byte),
    .val_o(timestamp_sh)
  );

  opensync_field_shift #(.WIDTH(32), .FIRST_IDX(SEQ_OFS)) u_seq_id (
    .clk(i_clk), .rst_n(i_rst_n), .en(cap_en), .idx(idx_q), .byte_in(rx_byte),
    .val_o(seq_id_sh)
  );

  opensync_field_shift #(.WIDTH(48), .FIRST_IDX(SMAC_OFS)) u_smac (
    .clk(i_clk), .rst_n(i_rst_n), .en(cap_en), .idx(idx_q), .byte_in(rx_byte),
    .val_o(smac_sh)
  );

`ifdef OPENSYNC_DMAC_CHECK_EN
  logic       mac_ok_q, mac_ok_d;
  logic       bc_ok_q, bc_ok_d;
  logic [7:0] mac_byte;

  // Unicast and broadcast matches are tracked in parallel; the frame is
  // rejected only when neither survives all six DMAC bytes.
  always_comb begin
    case (idx_q)
      6'd0:    mac_byte = iv_hcp_mac[47:40];
      6'd1:    mac_byte = iv_hcp_mac[39:32];
      6'd2:    mac_byte = iv_hcp_mac[31:24];
      6'd3:    mac_byte = iv_hcp_mac[23:16];
      6'd4:    mac_byte = iv_hcp_mac[15:8];
      6'd5:    mac_byte = iv_hcp_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
    mac_ok_d = mac_ok_q;
    bc_ok_d  = bc_ok_q;
    if (idx_q <= DMAC_LAST_IDX) begin
      mac_ok_d = (rx_byte == mac_byte) && ((idx_q == '0) || mac_ok_q);
      bc_ok_d  = (rx_byte == 8'hFF)    && ((idx_q == '0) || bc_ok_q);
    end
    dmac_bad = (idx_q == DMAC_LAST_IDX) && !(mac_ok_d || bc_ok_d);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mac_ok_q <= 1'b0;
      bc_ok_q  <= 1'b0;
    end else begin
      mac_ok_q <= mac_ok_d;
      bc_ok_q  <= bc_ok_d;
    end
  end
`else
  logic unused_hcp_mac;
  assign unused_hcp_mac = ^iv_hcp_mac;
  assign dmac_bad       = 1'b0;
`endif

  always_comb begin
    hdr_ok = 1'b1;
    case (idx_q)
      ETHTYPE_OFS:         hdr_ok = (rx_byte == TSMP_ETHTYPE[15:8]);
      ETHTYPE_OFS + 6'd1:  hdr_ok = (rx_byte == TSMP_ETHTYPE[7:0]);
      TYPE_OFS:            hdr_ok = (rx_byte == TSMP_TYPE_OPENSYNC);
      SUBTYPE_OFS:         hdr_ok = (rx_byte == OSYNC_SUB_TO_NODE);
      default:             hdr_ok = 1'b1;
    endcase
  end

  // Frame FSM: idx_q is always 0 in IDLE_S, so the start byte is index 0.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_en    = 1'b0;
    commit    = 1'b0;
    frame_bad = 1'b0;

    if (state_q == IDLE_S) begin
      if (i_data_wr && rx_delim) begin
        state_d = HEAD_S;
        idx_d   = IDX_W'(1);
      end
    end else if (!i_data_wr) begin
      frame_bad = 1'b1;
      state_d   = IDLE_S;
      idx_d     = '0;
    end else begin
      cap_en = 1'b1;
      idx_d  = idx_inc(idx_q);
      unique case (state_q)
        HEAD_S: begin
          if (rx_delim)                 frame_bad = 1'b1;
          else if (!hdr_ok || dmac_bad) state_d   = DISCARD_S;
          else if (idx_q == SUBTYPE_OFS) state_d  = PAYLOAD_S;
        end
        PAYLOAD_S: begin
          if (rx_delim) begin
            if (idx_q == MIN_LAST_IDX) commit    = 1'b1;
            else                       frame_bad = 1'b1;
          end else if (idx_q == MIN_LAST_IDX) begin
            state_d = TAIL_S;
          end
        end
        TAIL_S:    if (rx_delim) commit    = 1'b1;
        DISCARD_S: if (rx_delim) frame_bad = 1'b1;
        default:   state_d = IDLE_S;
      endcase
      if (rx_delim) begin
        state_d = IDLE_S;
        idx_d   = '0;
      end
    end
  end

  // Outputs only move on a committed frame; the shadows already include the last byte.
  always_comb begin
    err_cnt_d   = err_cnt_q;
    if (frame_bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
    msg_valid_d = commit;
    msg_type_d  = commit ? msg_type_sh  : msg_type_q;
    timestamp_d = commit ? timestamp_sh : timestamp_q;
    seq_id_d    = commit ? seq_id_sh    : seq_id_q;
    smac_d      = commit ? smac_sh      : smac_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE_S;
      idx_q       <= '0;
      err_cnt_q   <= '0;
      msg_valid_q <= 1'b0;
      msg_type_q  <= '0;
      timestamp_q <= '0;
      seq_id_q    <= '0;
      smac_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_cnt_q   <= err_cnt_d;
      msg_valid_q <= msg_valid_d;
      msg_type_q  <= msg_type_d;
      timestamp_q <= timestamp_d;
      seq_id_q    <= seq_id_d;
      smac_q      <= smac_d;
    end
  end

  assign o_msg_valid  = msg_valid_q;
  assign ov_msg_type  = msg_type_q;
  assign ov_timestamp = timestamp_q;
  assign ov_seq_id    = seq_id_q;
  assign ov_smac      = smac_q;
  assign ov_err_cnt   = err_cnt_q;

endmodule

// File: doc/opensync_parse.md
# opensync_parse

Node-side terminator for OpenSync TSMP frames in the tsmp_agent datapath: consumes the 9-bit byte stream carrying frames addressed to the master/slave node (TSMP subtype 0x03), validates the header, and extracts the sync payload into registers for the local time-sync logic. It is the receive end of the controller-to-node OpenSync path. It has no output stream; every input frame is either decoded or counted as an error.

## Interface
Parameters:
- none; field offsets and constants live in the shared package.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low
- iv_hcp_mac  in  48  local MAC, used when DMAC check compiled in
- iv_data  in  9  bit 8 = frame delimiter, set on first and last byte; bits 7:0 = byte
- i_data_wr  in  1  byte valid; high on every byte of a frame, contiguous
- o_msg_valid  out  1  one-cycle pulse: new decoded message on outputs
- ov_msg_type  out  8  payload byte 16
- ov_timestamp  out  64  payload bytes 17–24, big-endian
- ov_seq_id  out  32  payload bytes 25–28, big-endian
- ov_smac  out  48  frame bytes 6–11
- ov_err_cnt  out  16  saturating count of rejected frames

## Operation
- Byte index counter, 6 bits, saturates at 63; index 0 is the first byte.
- Header checks: bytes 12–13 = 0xFF,0x01; byte 14 = 0x06; byte 15 = 0x03. Any mismatch marks frame bad.
- Minimum length: the last byte must have index ≥ 28. A shorter frame is bad.
- Fields are captured into shadow registers as they arrive. Outputs are copied from the shadows only on a good frame.
- States:
  - IDLE_S: wait for i_data_wr with iv_data[8]=1, then go to HEAD_S with index 1. A byte without the start flag is ignored.
  - HEAD_S: indices 1–15; check the header. On mismatch go to DISCARD_S.
  - PAYLOAD_S: indices 16–28; capture fields.
  - TAIL_S: index > 28; wait for the delimiter.
  - DISCARD_S: wait for the delimiter.
- Delimiter (bit 8 = 1 with index ≥ 1) ends the frame:
  - In TAIL_S, or at index 28 in PAYLOAD_S: commit, pulse o_msg_valid, go to IDLE_S.
  - In HEAD_S or PAYLOAD_S with index < 28: bad frame, go to IDLE_S.
  - In DISCARD_S: go to IDLE_S.
- Bad frame: ov_err_cnt increments once, at the end of the frame. The counter holds at 0xFFFF.
- i_data_wr low mid-frame (any state except IDLE_S): abort, count one error, go to IDLE_S. A later delimiter is treated as a new start.
- Reset values: o_msg_valid 0, all fields 0, ov_err_cnt 0, state IDLE_S. Reset mid-frame drops the frame with no error count; bytes until the next start flag are ignored.

## Timing
- o_msg_valid rises the cycle after the last byte is sampled. Outputs update on that same edge and hold until the next pulse.
- Minimum gap between frames: 0 cycles. A start byte on the cycle after a last byte is accepted.
- No backpressure; one byte per cycle is sustained indefinitely.

## Configuration
- OPENSYNC_DMAC_CHECK_EN:
  - Defined: bytes 0–5 must equal iv_hcp_mac or FF:FF:FF:FF:FF:FF; otherwise the frame is bad.
  - Undefined: DMAC is not checked and no comparator is built.

## Structure
- Shared package holds:
  - state encodings
  - byte offsets (ETHTYPE_OFS=12, TYPE_OFS=14, SUBTYPE_OFS=15, PAYLOAD_OFS=16, MIN_LAST_IDX=28)
  - constants TSMP_ETHTYPE=16'hFF01, TSMP_TYPE_OPENSYNC=8'h06, OSYNC_SUB_TO_NODE=8'h03
- Natural sub-module: opensync_field_shift, a byte-indexed shift-capture register for the 64/32/48-bit fields.

## Test plan
- 60-byte frame to hcp MAC, header FF01/06/03, type 0x02, ts 0x0011223344556677, seq 0x0000ABCD -> one o_msg_valid the cycle after the last byte; ov_timestamp=0x0011223344556677; ov_seq_id=0xABCD; ov_err_cnt=0.
- Same frame with subtype 0x01 -> no pulse; ov_err_cnt=1; previous outputs unchanged.
- Frame with last byte at index 20 -> no pulse; ov_err_cnt +1. Back-to-back good frame with zero gap -> decoded correctly.
- i_data_wr deasserted at index 18 -> ov_err_cnt +1. Next good frame decodes.
- With macro defined, DMAC 02:00:00:00:00:99 ≠ hcp MAC -> error. Without macro -> decoded.
- ov_err_cnt preloaded to 0xFFFF by 65535 bad frames; one more bad frame -> stays 0xFFFF. Reset asserted at index 10 -> all outputs 0; next frame decodes.
